slot_payout: RTL and testbench

Consumer side of the slot-machine reel generator. Watches `running` and the generator's 4-bit `shift_reg` value. Latches one reel per spin stop; after three reels, scores the result. Manages the player credit count and dispenses payout coins one per handshake to the coin hopper.

---
 rtl/slot_pkg.sv | 17 +
 rtl/slot_payout_if.sv | 17 +
 rtl/slot_edge_det.sv | 20 ++
 rtl/slot_payout.sv | 167 ++++++++++++++++
 tb/tb_slot_payout.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// slot_payout shared types: FSM state, default payouts, reel value.
package slot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPIN,
    S_WAIT,
    S_EVAL,
    S_PAY
  } slot_state_t;

  localparam int JACKPOT_DEF = 10;
  localparam int PAIR_DEF    = 2;

  typedef logic [3:0] reel_t;

endpackage

// File: rtl/slot_payout_if.sv
// Coin hopper valid/ready handshake between slot_payout and the hopper.
interface slot_payout_if;

  logic coin_valid;
  logic coin_ready;

  modport master (
    output coin_valid,
    input  coin_ready
  );

  modport slave (
    input  coin_valid,
    output coin_ready
  );

endinterface

// File: rtl/slot_edge_det.sv
// Registers running and emits one-cycle start/stop pulses.
module slot_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic running,
  output logic start,
  output logic stop
);

  logic running_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) running_q <= 1'b0;
    else      running_q <= running;
  end

  assign start = running & ~running_q;
  assign stop  = ~running & running_q;

endmodule

// File: rtl/slot_payout.sv
// Slot machine scorer: latches 3 reels, scores, pays coins to hopper.
// Define SLOT_PAYOUT_PAIR_EN to make two equal reels pay PAIR_COINS.
module slot_payout
  import slot_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int CREDIT_W      = 8,
  parameter int JACKPOT_COINS = JACKPOT_DEF,
  parameter int PAIR_COINS    = PAIR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                running,
  input  logic [WIDTH-1:0]    reel_val,
  input  logic                coin_insert,
  slot_payout_if.master       hop,
  output logic [WIDTH-1:0]    reel0,
  output logic [WIDTH-1:0]    reel1,
  output logic [WIDTH-1:0]    reel2,
  output logic [CREDIT_W-1:0] credits,
  output logic                busy,
  output logic                win,
  output logic                jackpot
);

  localparam int PMAX =
    (JACKPOT_COINS > PAIR_COINS) ? JACKPOT_COINS : PAIR_COINS;
  localparam int PAY_W = $clog2(PMAX + 1);

  logic start;
  logic stop;

  slot_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .running (running),
    .start   (start),
    .stop    (stop)
  );

  slot_state_t         state, state_n;
  logic [1:0]          idx, idx_n;
  logic [PAY_W-1:0]    payout, pay_n;
  logic [WIDTH-1:0]    r0_n, r1_n, r2_n;
  logic [CREDIT_W-1:0] cred_n;
  logic                win_n, jp_n;
  logic                bet;
  logic                all3;
  logic                cv_q;

  assign all3 = (reel0 == reel1) && (reel1 == reel2);

`ifdef SLOT_PAYOUT_PAIR_EN
  logic pair;
  assign pair = (reel0 == reel1) || (reel1 == reel2) ||
                (reel0 == reel2);
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pay_n   = payout;
    r0_n    = reel0;
    r1_n    = reel1;
    r2_n    = reel2;
    win_n   = win;
    jp_n    = jackpot;
    bet     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && credits != '0) begin
          bet     = 1'b1;
          r0_n    = '0;
          r1_n    = '0;
          r2_n    = '0;
          win_n   = 1'b0;
          jp_n    = 1'b0;
          idx_n   = 2'd0;
          state_n = S_SPIN;
        end
      end
      S_SPIN: begin
        if (stop) begin
          unique case (idx)
            2'd0:    r0_n = reel_val;
            2'd1:    r1_n = reel_val;
            default: r2_n = reel_val;
          endcase
          if (idx == 2'd2) begin
            state_n = S_EVAL;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (start) state_n = S_SPIN;
      end
      S_EVAL: begin
        if (all3) begin
          jp_n  = 1'b1;
          win_n = 1'b1;
          pay_n = PAY_W'(JACKPOT_COINS);
        end
`ifdef SLOT_PAYOUT_PAIR_EN
        else if (pair) begin
          win_n = 1'b1;
          pay_n = PAY_W'(PAIR_COINS);
        end
`endif
        else begin
          pay_n = '0;
        end
        state_n = (pay_n != '0) ? S_PAY : S_IDLE;
      end
      S_PAY: begin
        // coin_valid is high for the whole PAY state
        if (hop.coin_ready) begin
          pay_n = payout - 1'b1;
          if (payout == PAY_W'(1)) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cred_n = credits;
    unique case ({coin_insert, bet})
      2'b10:   if (credits != '1) cred_n = credits + 1'b1;
      2'b01:   cred_n = credits - 1'b1;
      default: cred_n = credits;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      payout  <= '0;
      reel0   <= '0;
      reel1   <= '0;
      reel2   <= '0;
      credits <= '0;
      win     <= 1'b0;
      jackpot <= 1'b0;
      busy    <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      payout  <= pay_n;
      reel0   <= r0_n;
      reel1   <= r1_n;
      reel2   <= r2_n;
      credits <= cred_n;
      win     <= win_n;
      jackpot <= jp_n;
      busy    <= (state_n != S_IDLE);
      cv_q    <= (state_n == S_PAY);
    end
  end

  assign hop.coin_valid = cv_q;

endmodule

// File: tb/tb_slot_payout.sv
// Directed bench for slot_payout with an expected-score queue.
module tb_slot_payout;

  typedef struct {
    logic win;
    logic jp;
    int   coins;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       running;
  logic [3:0] reel_val;
  logic       coin_insert;
  logic [3:0] reel0, reel1, reel2;
  logic [7:0] credits;
  logic       busy, win, jackpot;

  slot_payout_if hop ();

  slot_payout dut (
    .clk         (clk),
    .rst         (rst),
    .running     (running),
    .reel_val    (reel_val),
    .coin_insert (coin_insert),
    .hop         (hop),
    .reel0       (reel0),
    .reel1       (reel1),
    .reel2       (reel2),
    .credits     (credits),
    .busy        (busy),
    .win         (win),
    .jackpot     (jackpot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   passed = 0;
  int   total  = 0;
  int   exp_cr = 0;
  exp_t sb[$];
  exp_t cur;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t score(int a, int b, int c);
    exp_t e;
    e.win = 1'b0;
    e.jp = 1'b0;
    e.coins = 0;
    if (a == b && b == c) begin
      e.win = 1'b1;
      e.jp = 1'b1;
      e.coins = 10;
    end
`ifdef SLOT_PAYOUT_PAIR_EN
    else if (a == b || b == c || a == c) begin
      e.win = 1'b1;
      e.coins = 2;
    end
`endif
    return e;
  endfunction

  task automatic insert();
    coin_insert = 1'b1;
    tick();
    coin_insert = 1'b0;
    if (exp_cr < 255) exp_cr++;
  endtask

  task automatic spin(logic [3:0] v, logic ins);
    running = 1'b1;
    coin_insert = ins;
    tick();
    coin_insert = 1'b0;
    tick();
    reel_val = v;
    running = 1'b0;
    tick();
    reel_val = ~v;
  endtask

  task automatic spin_game(logic [3:0] a, logic [3:0] b,
                           logic [3:0] c, logic ins);
    sb.push_back(score(a, b, c));
    spin(a, ins);
    if (!ins) exp_cr--;
    chk("bet_credits", credits, exp_cr);
    chk("win_cleared", win, 0);
    chk("jp_cleared", jackpot, 0);
    chk("reel1_cleared", reel1, 0);
    chk("reel0_latch", reel0, a);
    spin(b, 1'b0);
    spin(c, 1'b0);
    chk("reel1_latch", reel1, b);
    chk("reel2_latch", reel2, c);
    chk("busy_eval", busy, 1);
    chk("win_eval", win, 0);
    tick();
    cur = sb.pop_front();
    chk("win", win, cur.win);
    chk("jackpot", jackpot, cur.jp);
  endtask

  task automatic pay(logic toggle);
    int rem;
    rem = cur.coins;
    for (int i = 0; rem > 0 && i < 64; i++) begin
      hop.coin_ready = toggle ? (i % 2 == 0) : 1'b1;
      chk("coin_valid_hi", hop.coin_valid, 1);
      if (hop.coin_ready) rem--;
      tick();
    end
    hop.coin_ready = 1'b1;
    chk("coin_valid_end", hop.coin_valid, 0);
    chk("busy_end", busy, 0);
    chk("credits_end", credits, exp_cr);
  endtask

  initial begin
    rst = 1'b0;
    running = 1'b0;
    reel_val = 4'd0;
    coin_insert = 1'b0;
    hop.coin_ready = 1'b1;
    #30;
    rst = 1'b1;
    tick();
    chk("rst_credits", credits, 0);
    chk("rst_reel0", reel0, 0);
    chk("rst_reel1", reel1, 0);
    chk("rst_reel2", reel2, 0);
    chk("rst_win", win, 0);
    chk("rst_jackpot", jackpot, 0);
    chk("rst_valid", hop.coin_valid, 0);
    chk("rst_busy", busy, 0);

    running = 1'b1;
    tick();
    tick();
    chk("nocred_busy", busy, 0);
    chk("nocred_credits", credits, 0);
    running = 1'b0;
    tick();
    tick();
    chk("nocred_busy2", busy, 0);

    repeat (3) insert();
    chk("credits3", credits, exp_cr);

    spin_game(4'd7, 4'd7, 4'd7, 1'b0);
    pay(1'b0);
    spin_game(4'd3, 4'd3, 4'd9, 1'b0);
    pay(1'b0);
    spin_game(4'd5, 4'd5, 4'd5, 1'b0);
    pay(1'b1);

    insert();
    spin_game(4'd1, 4'd2, 4'd3, 1'b1);
    pay(1'b0);

    spin_game(4'd4, 4'd4, 4'd4, 1'b0);
    hop.coin_ready = 1'b0;
    tick();
    chk("valid_hold_mid", hop.coin_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", hop.coin_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_win", win, 0);
    chk("arst_credits", credits, 0);
    chk("arst_reel0", reel0, 0);
    #3;
    rst = 1'b1;
    hop.coin_ready = 1'b1;
    exp_cr = 0;
    tick();
    chk("post_rst_busy", busy, 0);

    repeat (256) insert();
    chk("credits_sat", credits, 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
